// File: rtl/inst_sram_resp_pkg.sv
// Shared constants and types for the instruction-SRAM responder.
//   DEFWIDTH             : datapath width of the fetch bus
//   INST_SRAM_BASE       : byte address mapped to word 0 (reset fetch address)
//   INST_SRAM_DEPTH_LOG2 : log2 of the word count
//   NOP_INST             : word returned for out-of-range / misaligned reads
//   INST_SRAM_BUS_W      : total width of the en/wen/addr/wdata/rdata bundle
package inst_sram_resp_pkg;

  localparam int          DEFWIDTH             = 32;
  localparam logic [31:0] INST_SRAM_BASE       = 32'h8000_0000;
  localparam int          INST_SRAM_DEPTH_LOG2 = 12;
  localparam logic [31:0] NOP_INST             = 32'h0000_0013;
  localparam int          INST_SRAM_BUS_W      = 1 + 1 + 3 * DEFWIDTH;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_kind_e;

  function automatic acc_kind_e acc_kind(input logic en, input logic wen);
    if (!en)      return ACC_IDLE;
    else if (wen) return ACC_WRITE;
    else          return ACC_READ;
  endfunction

endpackage

// File: rtl/inst_sram_resp_if.sv
// Fetch-stage instruction-SRAM bus.
//   master : fetch stage (drives en/wen/addr/wdata, receives rdata)
//   slave  : inst_sram_resp (receives requests, drives rdata)
interface inst_sram_resp_if;
  import inst_sram_resp_pkg::*;

  logic                inst_sram_en;
  logic                inst_sram_wen;
  logic [DEFWIDTH-1:0] inst_sram_addr;
  logic [DEFWIDTH-1:0] inst_sram_wdata;
  logic [DEFWIDTH-1:0] inst_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata
  );

endinterface

// File: rtl/inst_sram_resp_sram_1rw_sp.sv
// sram_1rw_sp: word array with registered synchronous read.
//   rd_en/rd_addr -> rd_data_q : read captured at the edge, held otherwise
//   wr_en/wr_addr/wr_data      : fetch-port write lane
//   ld_en/ld_addr/ld_data      : back-door load lane, wins over wr on the same word
// Reads see the contents from before any write at the same edge.
// No reset: array and read register are left as-is.
module sram_1rw_sp #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data_q,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data_q <= mem_q[rd_addr];
    if (wr_en) mem_q[wr_addr] <= wr_data;
    // Later assignment wins, so a load on the same word overrides the port write.
    if (ld_en) mem_q[ld_addr] <= ld_data;
  end

endmodule

// File: rtl/inst_sram_resp.sv
// inst_sram_resp: slave end of the fetch-stage instruction SRAM bus.
// One-cycle read latency, no backpressure; back-door load port for the
// program image (honoured even while reset is high).
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : en/wen/addr/wdata in, rdata out
//   ld_valid/addr/data: back-door word load, no address checks
//   acc_err           : last enabled access was out-of-range or misaligned
//   rd_cnt, wr_cnt    : saturating access counters, only with INST_SRAM_PERF_EN
// Optional build macro: INST_SRAM_PERF_EN.
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = INST_SRAM_BASE,
  parameter int          DEPTH_LOG2 = INST_SRAM_DEPTH_LOG2,
  parameter logic [31:0] OOR_DATA   = NOP_INST
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_sram_resp_if.slave       bus,
  input  logic                  ld_valid,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data,
`ifdef INST_SRAM_PERF_EN
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt,
`endif
  output logic                  acc_err
);

  logic [31:0]           off;
  logic                  in_range;
  logic                  aligned;
  logic                  legal;
  logic [DEPTH_LOG2-1:0] idx;
  acc_kind_e             kind;
  logic                  rd_fire;
  logic                  wr_fire;
  logic [31:0]           sram_rdata;

  logic rd_ok_q, rd_ok_d;
  logic acc_err_q, acc_err_d;

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  assign off      = bus.inst_sram_addr - BASE_ADDR;
  assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign aligned  = bus.inst_sram_addr[1:0] == 2'b00;
  assign legal    = in_range & aligned;
  assign idx      = off[DEPTH_LOG2+1:2];

  // Port accesses are ignored while reset is high; only the load lane runs.
  assign kind    = acc_kind(bus.inst_sram_en & ~reset, bus.inst_sram_wen);
  assign rd_fire = (kind == ACC_READ)  && legal;
  assign wr_fire = (kind == ACC_WRITE) && legal;

  sram_1rw_sp #(.AW(DEPTH_LOG2), .DW(32)) u_sram (
    .clk      (clk),
    .rd_en    (rd_fire),
    .rd_addr  (idx),
    .rd_data_q(sram_rdata),
    .wr_en    (wr_fire),
    .wr_addr  (idx),
    .wr_data  (bus.inst_sram_wdata),
    .ld_en    (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  // rd_ok_q selects between the array's read register and OOR_DATA; the
  // array register only moves on legal reads, so holds fall out naturally.
  always_comb begin
    rd_ok_d   = rd_ok_q;
    acc_err_d = acc_err_q;
    if (kind != ACC_IDLE) acc_err_d = ~legal;
    if (kind == ACC_READ) rd_ok_d   = legal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ok_q   <= 1'b0;
      acc_err_q <= 1'b0;
    end else begin
      rd_ok_q   <= rd_ok_d;
      acc_err_q <= acc_err_d;
    end
  end

  assign bus.inst_sram_rdata = rd_ok_q ? sram_rdata : OOR_DATA;
  assign acc_err             = acc_err_q;

`ifdef INST_SRAM_PERF_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if ((kind == ACC_READ) && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_d = rd_cnt_q + 32'd1;
    if (wr_fire && (wr_cnt_q != 32'hFFFF_FFFF))            wr_cnt_d = wr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_inst_sram_resp.sv
module tb_inst_sram_resp;
  import inst_sram_resp_pkg::*;

  localparam int          NW   = 4096;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ld_valid;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;
  logic        acc_err;
`ifdef INST_SRAM_PERF_EN
  logic [31:0] rd_cnt, wr_cnt;
`endif

  inst_sram_resp_if bus ();

  inst_sram_resp dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .ld_valid(ld_valid),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
`ifdef INST_SRAM_PERF_EN
    .rd_cnt  (rd_cnt),
    .wr_cnt  (wr_cnt),
`endif
    .acc_err (acc_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: word store plus expected output registers.
  logic [31:0] m_mem [NW];
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] m_rd;
  logic [31:0] m_wr;
  bit          chk_on = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Legal = within 16 KiB above BASE and word aligned.
  function automatic bit legal_addr(input logic [31:0] a, output logic [11:0] ix);
    logic [31:0] off;
    off = a - BASE;
    ix  = off[13:2];
    return (off < 32'h0000_4000) && (a[1:0] == 2'b00);
  endfunction

  task automatic cyc(input bit rst, input bit en, input bit wen,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input bit ld, input logic [11:0] la, input logic [31:0] ldd);
    logic [11:0] ix;
    bit          lg;
    reset               = rst;
    bus.inst_sram_en    = en;
    bus.inst_sram_wen   = wen;
    bus.inst_sram_addr  = addr;
    bus.inst_sram_wdata = wdata;
    ld_valid            = ld;
    ld_addr             = la;
    ld_data             = ldd;
    @(posedge clk);
    lg = legal_addr(addr, ix);
    if (rst) begin
      m_rdata = NOP;
      m_err   = 1'b0;
      m_rd    = 32'd0;
      m_wr    = 32'd0;
    end else if (en) begin
      m_err = !lg;
      if (!wen) begin
        m_rdata = lg ? m_mem[ix] : NOP;
        if (m_rd != 32'hFFFF_FFFF) m_rd++;
      end else if (lg) begin
        m_mem[ix] = wdata;
        if (m_wr != 32'hFFFF_FFFF) m_wr++;
      end
    end
    if (ld) m_mem[la] = ldd;
    chk_on = 1'b1;
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(0, 1, 0, a, 32'h0, 0, 12'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(0, 1, 1, a, d, 0, 12'h0, 32'h0);
  endtask

  task automatic ld(input bit rst, input logic [11:0] la, input logic [31:0] d);
    cyc(rst, 0, 0, 32'h0, 32'h0, 1, la, d);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 32'h0, 32'h0, 0, 12'h0, 32'h0);
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk32("rdata", bus.inst_sram_rdata, m_rdata);
      chk32("acc_err", {31'b0, acc_err}, {31'b0, m_err});
`ifdef INST_SRAM_PERF_EN
      chk32("rd_cnt", rd_cnt, m_rd);
      chk32("wr_cnt", wr_cnt, m_wr);
`endif
    end
  end

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6) begin
      if ($urandom_range(0, 1) == 0) return BASE + ($urandom_range(0, 15) << 2);
      return BASE + ($urandom_range(0, NW - 1) << 2);
    end
    if (r == 7) return BASE + ($urandom_range(0, NW - 1) << 2) + $urandom_range(1, 3);
    if (r == 8) return BASE - ($urandom_range(1, 100) << 2);
    return BASE + 32'h0000_4000 + ($urandom_range(0, 1000) << 2);
  endfunction

  initial begin
    reset               = 1'b1;
    bus.inst_sram_en    = 1'b0;
    bus.inst_sram_wen   = 1'b0;
    bus.inst_sram_addr  = 32'h0;
    bus.inst_sram_wdata = 32'h0;
    ld_valid            = 1'b0;
    ld_addr             = 12'h0;
    ld_data             = 32'h0;

    // Program image fill during reset.
    for (int i = 0; i < NW; i++) ld(1, i[11:0], $urandom);
    ld(1, 12'd0, 32'h0010_0093);
    chk32("reset_rdata", bus.inst_sram_rdata, NOP);
    chk32("reset_err", {31'b0, acc_err}, 32'd0);

    // Reset exit: first fetch.
    rd(BASE);
    chk32("exit_rdata", bus.inst_sram_rdata, 32'h0010_0093);
    chk32("exit_err", {31'b0, acc_err}, 32'd0);

    // Streaming reads, no bubbles.
    for (int i = 0; i < 8; i++) ld(0, i[11:0], 32'hA000_0000 + i);
    for (int i = 0; i < 8; i++) begin
      rd(BASE + 4 * i);
      chk32("stream", bus.inst_sram_rdata, 32'hA000_0000 + i);
    end

    // Hold with en low.
    ld(0, 12'd1, 32'h1234_5678);
    rd(32'h8000_0004);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk32("hold", bus.inst_sram_rdata, 32'h1234_5678);
    end

    // Range / alignment.
    rd(32'h7FFF_FFFC);
    chk32("below_rdata", bus.inst_sram_rdata, NOP);
    chk32("below_err", {31'b0, acc_err}, 32'd1);
    rd(32'h8000_0002);
    chk32("misal_rdata", bus.inst_sram_rdata, NOP);
    chk32("misal_err", {31'b0, acc_err}, 32'd1);
    rd(32'h8000_4000);
    chk32("above_rdata", bus.inst_sram_rdata, NOP);
    chk32("above_err", {31'b0, acc_err}, 32'd1);
    rd(32'h8000_0004);
    chk32("clear_err", {31'b0, acc_err}, 32'd0);
    chk32("clear_rdata", bus.inst_sram_rdata, 32'h1234_5678);

    // Collisions on word 3.
    ld(0, 12'd3, 32'hDEAD_BEEF);
    cyc(0, 1, 0, 32'h8000_000C, 32'h0, 1, 12'd3, 32'h2222_2222);
    chk32("rd_vs_ld", bus.inst_sram_rdata, 32'hDEAD_BEEF);
    ld(0, 12'd3, 32'hDEAD_BEEF);
    cyc(0, 1, 1, 32'h8000_000C, 32'h1111_1111, 1, 12'd3, 32'h2222_2222);
    rd(32'h8000_000C);
    chk32("wr_vs_ld", bus.inst_sram_rdata, 32'h2222_2222);

    // Mid-stream reset discards the pending word, keeps the array.
    rd(32'h8000_0004);
    cyc(1, 1, 0, 32'h8000_0004, 32'h0, 0, 12'h0, 32'h0);
    chk32("midrst_rdata", bus.inst_sram_rdata, NOP);
    rd(32'h8000_0004);
    chk32("after_rst", bus.inst_sram_rdata, 32'h1234_5678);

`ifdef INST_SRAM_PERF_EN
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 12'h0, 32'h0);
    for (int i = 0; i < 10; i++) rd(BASE + 4 * i);
    for (int i = 0; i < 3; i++) wr(BASE + 32'h100 + 4 * i, 32'h5555_0000 + i);
    wr(32'h7FFF_FFFC, 32'hBAD0_0001);
    wr(32'h8000_0001, 32'hBAD0_0002);
    for (int i = 0; i < 4; i++) ld(0, 12'd200 + i[11:0], 32'h7777_0000 + i);
    chk32("perf_rd", rd_cnt, 32'd10);
    chk32("perf_wr", wr_cnt, 32'd3);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 12'h0, 32'h0);
    chk32("perf_rd_rst", rd_cnt, 32'd0);
    chk32("perf_wr_rst", wr_cnt, 32'd0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit          r_rst, r_en, r_wen, r_ld;
      logic [11:0] r_la;
      r_rst = ($urandom_range(0, 49) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_wen = ($urandom_range(0, 9) < 3);
      r_ld  = ($urandom_range(0, 4) == 0);
      r_la  = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom_range(0, NW - 1));
      cyc(r_rst, r_en, r_wen, rand_addr(), $urandom, r_ld, r_la, $urandom);
    end

    chk_on = 1'b0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_sram_resp.md
Name: inst_sram_resp

Overview:
- Instruction-memory responder: the slave end of the fetch-stage instruction SRAM interface (en/addr/wen/wdata -> rdata).
- Word-organised synchronous SRAM model with fixed one-cycle read latency, as the fetch stage expects.
- Includes a back-door load port so the bench or boot logic can fill the program image while the core is held in reset.
- Sits beside the core in the SoC/sim top; the core's fetch stage connects directly to it.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0 (first fetch after reset).
- DEPTH_LOG2, 12, log2 of word count (default 4096 words = 16 KiB).
- OOR_DATA, 32'h0000_0013, word returned for out-of-range or misaligned reads (NOP).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_sram_en  in  1  access enable
- inst_sram_wen  in  1  write enable, qualified by en
- inst_sram_addr  in  32  byte address
- inst_sram_wdata  in  32  write data
- inst_sram_rdata  out  32  read data, valid the cycle after an enabled read
- ld_valid  in  1  back-door load strobe
- ld_addr  in  DEPTH_LOG2  word index for load
- ld_data  in  32  load data
- acc_err  out  1  registered flag: last enabled access was out-of-range or misaligned

Behaviour:
- Reset (sync, active-high): rdata_q=OOR_DATA, acc_err=0. The memory array is NOT cleared. ld_valid writes are still honoured during reset.
- Index: off = addr - BASE_ADDR (32-bit, wrapping).
  - in_range when off[31:DEPTH_LOG2+2]==0.
  - aligned when addr[1:0]==0.
  - idx = off[DEPTH_LOG2+1:2].
- Read (en=1, wen=0), with edge N the clock edge at which the request is sampled:
  - rdata_q <= mem[idx] at edge N, visible through the cycle after N.
  - If !in_range or !aligned: rdata_q <= OOR_DATA and acc_err <= 1.
  - Otherwise acc_err <= 0.
- Hold: when en=0, rdata_q and acc_err keep their previous values. Fetch stalls rely on this.
- Write (en=1, wen=1):
  - Legal address: mem[idx] <= wdata. rdata_q is held (not updated). acc_err <= 0.
  - Illegal address: write dropped, acc_err <= 1.
- Back-door load: ld_valid=1 writes mem[ld_addr] <= ld_data at the edge, with no address checks.
- Collisions on the same index in the same cycle:
  - Port write vs. ld write: ld wins and the port write is dropped.
  - Read vs. ld write: the read returns the OLD contents (read-before-write).
- Latency: fixed 1 cycle. No backpressure and no ready signal. Every enabled read is answered on the next edge.
- Back-to-back reads: supported every cycle with no bubbles.
- Reset asserted mid-stream: the pending rdata is replaced by OOR_DATA on that edge. The array contents are preserved.
- Address wrap: addr below BASE_ADDR wraps to a huge offset and is treated as out-of-range.

Optional Feature:
- INST_SRAM_PERF_EN defined:
  - Adds outputs rd_cnt[31:0] and wr_cnt[31:0], reset to 0.
  - rd_cnt increments on each enabled read; wr_cnt increments on each enabled legal write. Both saturate at 32'hFFFF_FFFF.
  - Back-door loads are not counted.
- Not defined: the ports and logic are absent; everything else is identical.

Decomposition:
- Shared package/header (alongside DEFWIDTH): INST_SRAM_BASE, INST_SRAM_DEPTH_LOG2, NOP_INST constants; the instruction-SRAM port bundle width.
- One sub-module, sram_1rw_sp: plain single-port array with sync read, write enable and read-before-write semantics.
- inst_sram_resp wraps sram_1rw_sp and adds address decode, the ld mux, the error flag and the optional counters.

Test Plan:
- Reset-exit: load mem[0]=32'h0010_0093 via ld during reset; deassert reset; read addr 32'h8000_0000 -> rdata=32'h0010_0093 on the next cycle, acc_err=0.
- Streaming: load words 0..7 with 32'hA000_0000+i; read 8 consecutive addresses back-to-back -> rdata follows 1 cycle later with no gaps.
- Hold: read 32'h8000_0004 (word=32'h1234_5678), then en=0 for 5 cycles -> rdata stays 32'h1234_5678.
- Range/alignment: read 32'h7FFF_FFFC, read 32'h8000_0002, read 32'h8000_4000 -> each returns 32'h0000_0013 with acc_err=1; a following legal read clears acc_err.
- Collision: hold word 3 = 32'hDEAD_BEEF; in the same cycle, port write 32'h1111_1111 and ld write 32'h2222_2222 to word 3; then read word 3 -> 32'h2222_2222. A read concurrent with ld returns the old value 32'hDEAD_BEEF.
- PERF (INST_SRAM_PERF_EN defined): 10 reads, 3 legal writes, 2 illegal writes, 4 ld loads -> rd_cnt=10, wr_cnt=3; reset -> both 0.
